// File: rtl/ddr_test_pkg.sv
// Shared constants for the DDR input throughput test: FSM encoding,
// the 5-bit XNOR LFSR definition and the seeding limits.
package ddr_test_pkg;

  localparam int LFSR_W = 5;
  localparam int TAP_A  = 4;
  localparam int TAP_B  = 2;
  // XNOR feedback: the all-zero state is legal, all-ones is the lock state
  localparam logic XNOR_FB = 1'b1;

  localparam int SEED_CYCLES = 3;
  localparam int MAX_RETRY   = 3;
  localparam logic [LFSR_W-1:0] LOCK_PATTERN = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ddr_lfsr_check_ctrl_if.sv
// Control, captured DDR bit pair and result bundle of the checker.
interface ddr_lfsr_check_ctrl_if #(
  parameter int ERR_W = 8
);
  import ddr_test_pkg::*;

  logic             start;
  logic             abort;
  logic             din_early;
  logic             din_late;
  state_t           state;
  logic             busy;
  logic             done;
  logic             pass;
  logic             lockup;
  logic [ERR_W-1:0] err_count;

  modport master (
    output start, abort, din_early, din_late,
    input  state, busy, done, pass, lockup, err_count
  );

  modport slave (
    input  start, abort, din_early, din_late,
    output state, busy, done, pass, lockup, err_count
  );

endinterface

// File: rtl/ddr_lfsr_step2.sv
// Advances the LFSR model by two bits: p0 is the earlier predicted bit,
// p1 the later one, s_next the state after both are shifted in.
module ddr_lfsr_step2
  import ddr_test_pkg::*;
(
  input  logic [LFSR_W-1:0] s,
  output logic              p0,
  output logic              p1,
  output logic [LFSR_W-1:0] s_next
);

  // p1 uses taps one position lower because p0 has already been shifted in
  assign p0     = XNOR_FB ^ s[TAP_A] ^ s[TAP_B];
  assign p1     = XNOR_FB ^ s[TAP_A-1] ^ s[TAP_B-1];
  assign s_next = {s[LFSR_W-3:0], p0, p1};

endmodule

// File: rtl/ddr_lfsr_check_ctrl.sv
// Seeds a local LFSR model from the received DDR bit pairs, then counts
// mismatches against the free-running prediction for RUN_CYCLES cycles.
module ddr_lfsr_check_ctrl
  import ddr_test_pkg::*;
#(
  parameter int RUN_CYCLES = 64,
  parameter int ERR_W      = 8,
  parameter int CNT_W      = 8
) (
  input logic             clk,
  input logic             rst,
  ddr_lfsr_check_ctrl_if.slave bus
);

  localparam logic [ERR_W-1:0] ERR_MAX    = '1;
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEED_LAST  = CNT_W'(SEED_CYCLES - 1);
  localparam logic [1:0]       RETRY_LAST = 2'(MAX_RETRY - 1);

  state_t            r_state, w_state_next;
  logic [LFSR_W-1:0] r_s, w_s_next;
  logic [CNT_W-1:0]  r_run_cnt, w_run_cnt_next;
  logic [1:0]        r_retry, w_retry_next;
  logic [ERR_W-1:0]  r_err, w_err_next;
  logic              r_lockup, w_lockup_next;
  logic              r_pass, w_pass_next;

  logic              w_p0, w_p1;
  logic [LFSR_W-1:0] w_s_pred, w_s_seed;
  logic [1:0]        w_nerr;
  logic [ERR_W:0]    w_err_sum;
  logic [ERR_W-1:0]  w_err_sat;

  ddr_lfsr_step2 u_step (
    .s      (r_s),
    .p0     (w_p0),
    .p1     (w_p1),
    .s_next (w_s_pred)
  );

  assign w_s_seed  = {r_s[LFSR_W-3:0], bus.din_early, bus.din_late};
  assign w_nerr    = {1'b0, bus.din_early ^ w_p0} + {1'b0, bus.din_late ^ w_p1};
  // One extra bit catches the wrap so +1 or +2 near the top clamps to all-ones
  assign w_err_sum = {1'b0, r_err} + {{(ERR_W-1){1'b0}}, w_nerr};
  assign w_err_sat = w_err_sum[ERR_W] ? ERR_MAX : w_err_sum[ERR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_run_cnt <= '0;
      r_retry   <= '0;
      r_err     <= '0;
      r_lockup  <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_s       <= w_s_next;
      r_run_cnt <= w_run_cnt_next;
      r_retry   <= w_retry_next;
      r_err     <= w_err_next;
      r_lockup  <= w_lockup_next;
      r_pass    <= w_pass_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_s_next       = r_s;
    w_run_cnt_next = r_run_cnt;
    w_retry_next   = r_retry;
    w_err_next     = r_err;
    w_lockup_next  = r_lockup;
    w_pass_next    = r_pass;

    if (bus.abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            w_state_next   = ST_SEED;
            w_run_cnt_next = '0;
            w_retry_next   = '0;
            w_err_next     = '0;
            w_lockup_next  = 1'b0;
            w_pass_next    = 1'b0;
          end
        end
        ST_SEED: begin
          w_s_next       = w_s_seed;
          w_run_cnt_next = r_run_cnt + 1'b1;
          if (r_run_cnt == SEED_LAST) begin
            w_run_cnt_next = '0;
            if (w_s_seed == LOCK_PATTERN) begin
              w_retry_next = r_retry + 2'd1;
              if (r_retry == RETRY_LAST) begin
                w_lockup_next = 1'b1;
                w_state_next  = ST_DONE;
              end
            end else begin
              w_state_next = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          w_s_next       = w_s_pred;
          w_err_next     = w_err_sat;
          w_run_cnt_next = r_run_cnt + 1'b1;
          if (r_run_cnt == RUN_LAST) begin
            w_run_cnt_next = '0;
            w_state_next   = ST_DONE;
            w_pass_next    = (w_err_sat == '0);
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  assign bus.state     = r_state;
  assign bus.busy      = (r_state == ST_SEED) || (r_state == ST_CHECK);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.pass      = r_pass;
  assign bus.lockup    = r_lockup;
  assign bus.err_count = r_err;

endmodule

// File: tb/tb_ddr_lfsr_check_ctrl.sv
// Randomised scoreboard bench for ddr_lfsr_check_ctrl: expectations are
// queued at start time, a monitor compares them when done rises.
module tb_ddr_lfsr_check_ctrl;

  localparam int RUN   = 64;
  localparam int EW    = 6;
  localparam int EMAX  = (1 << EW) - 1;
  localparam int NCYC  = 80;
  localparam int TXLEN = 512;

  typedef struct {
    int done_cyc;
    int err;
    int pass;
    int lockup;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t exp_q[$];
  bit   txb[TXLEN];
  bit   drv_e[NCYC];
  bit   drv_l[NCYC];

  ddr_lfsr_check_ctrl_if #(.ERR_W(EW)) bus ();

  ddr_lfsr_check_ctrl #(
    .RUN_CYCLES (RUN),
    .ERR_W      (EW),
    .CNT_W      (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: seed from the last 5 of each 6-bit window, then predict
  // with b[t] = ~(b[t-5] ^ b[t-3]) and count mismatched bits.
  function automatic exp_t model(input int n);
    exp_t x;
    bit   q[$];
    int   idx = 0;
    int   tries;
    bit   p;
    int   err = 0;
    for (tries = 0; tries < 3; tries++) begin
      q.delete();
      for (int c = 0; c < 3; c++) begin
        q.push_back(drv_e[idx]);
        q.push_back(drv_l[idx]);
        idx++;
      end
      if (!(q[1] && q[2] && q[3] && q[4] && q[5])) break;
    end
    if (tries == 3) begin
      x.lockup = 1; x.pass = 0; x.err = 0; x.done_cyc = n + 1 + idx;
    end else begin
      for (int c = 0; c < RUN; c++) begin
        p = !(q[$-4] ^ q[$-2]);
        q.push_back(p);
        if (drv_e[idx] != p) err++;
        p = !(q[$-4] ^ q[$-2]);
        q.push_back(p);
        if (drv_l[idx] != p) err++;
        idx++;
      end
      x.lockup = 0;
      x.err = (err > EMAX) ? EMAX : err;
      x.pass = (err == 0) ? 1 : 0;
      x.done_cyc = n + 1 + idx;
    end
    return x;
  endfunction

  // Modes: 0 clean, 1 late bit inverted for 5 cycles, 2 both inverted
  // across the whole check, 3 constant ones, 4 random offset/retries/errors
  task automatic fill(input int mode);
    int off;
    int nretry;
    int ci;
    off = (mode == 4) ? int'($urandom_range(0, 30)) : 0;
    nretry = 0;
    if (mode == 4 && $urandom_range(0, 2) == 0) nretry = int'($urandom_range(1, 2));
    for (int i = 0; i < NCYC; i++) begin
      drv_e[i] = txb[off + 2*i];
      drv_l[i] = txb[off + 2*i + 1];
      ci = i - 3*(nretry + 1);
      if (mode == 3 || i < 3*nretry) begin
        drv_e[i] = 1'b1;
        drv_l[i] = 1'b1;
      end else if (mode == 1 && ci >= 10 && ci < 15) begin
        drv_l[i] = !drv_l[i];
      end else if (mode == 2 && ci >= 0 && ci < RUN) begin
        drv_e[i] = !drv_e[i];
        drv_l[i] = !drv_l[i];
      end else if (mode == 4 && ci >= 0) begin
        if ($urandom_range(0, 15) == 0) drv_e[i] = !drv_e[i];
        if ($urandom_range(0, 15) == 0) drv_l[i] = !drv_l[i];
      end
    end
  endtask

  task automatic run_test(input int mode);
    exp_t x;
    int   n;
    fill(mode);
    @(posedge clk); #1;
    n = cyc;
    x = model(n);
    exp_q.push_back(x);
    bus.start     = 1'b1;
    bus.din_early = 1'($urandom_range(0, 1));
    bus.din_late  = 1'($urandom_range(0, 1));
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.din_early = drv_e[i];
      bus.din_late  = drv_l[i];
    end
  endtask

  task automatic abort_test();
    fill(0);
    for (int i = 5; i < 8; i++) drv_l[i] = !drv_l[i];
    @(posedge clk); #1;
    bus.start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (i == 14) check("start_ignored_state", int'(bus.state), 2);
      if (i == 24) begin
        check("abort_state", int'(bus.state), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_err_kept", int'(bus.err_count), 3);
      end
      bus.start     = (i == 13);
      bus.abort     = (i == 23);
      bus.din_early = drv_e[i];
      bus.din_late  = drv_l[i];
    end
    check("abort_stays_idle", int'(bus.state), 0);
    check("abort_err_final", int'(bus.err_count), 3);
    $display("abort run: state=%0d err=%0d", bus.state, bus.err_count);
  endtask

  task automatic reset_test();
    fill(0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.din_early = drv_e[i];
      bus.din_late  = drv_l[i];
      if (i == 29) begin
        #2;
        rst = 1'b1;
        #1;
        check("rst_state", int'(bus.state), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_pass", int'(bus.pass), 0);
        check("rst_lockup", int'(bus.lockup), 0);
        check("rst_err", int'(bus.err_count), 0);
        rst = 1'b0;
      end
    end
    check("post_rst_idle", int'(bus.state), 0);
    $display("reset run: state=%0d done=%0d", bus.state, bus.done);
  endtask

  initial begin : monitor
    exp_t x;
    bit   prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          x = exp_q.pop_front();
          $display("run done: cycle=%0d exp=%0d err=%0d exp=%0d pass=%0d exp=%0d lockup=%0d exp=%0d",
                   cyc, x.done_cyc, bus.err_count, x.err, bus.pass, x.pass, bus.lockup, x.lockup);
          check("done_cycle", cyc, x.done_cyc);
          check("err_count", int'(bus.err_count), x.err);
          check("pass", int'(bus.pass), x.pass);
          check("lockup", int'(bus.lockup), x.lockup);
        end
      end
      prev_done = bus.done;
    end
  end

  initial begin : stimulus
    for (int t = 0; t < TXLEN; t++) begin
      bit a;
      bit c;
      a = (t >= 5) ? txb[t-5] : 1'b0;
      c = (t >= 3) ? txb[t-3] : 1'b0;
      txb[t] = !(a ^ c);
    end
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.din_early = 1'b0;
    bus.din_late  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", int'(bus.state), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_pass", int'(bus.pass), 0);
    check("reset_lockup", int'(bus.lockup), 0);
    check("reset_err", int'(bus.err_count), 0);
    rst = 1'b0;

    run_test(0);
    run_test(1);
    run_test(2);
    run_test(3);
    abort_test();
    reset_test();
    run_test(0);
    for (int k = 0; k < 8; k++) run_test(4);

    repeat (5) @(posedge clk);
    #1;
    check("pending_runs", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
